multicycle_control: RTL and testbench
=====================================

// Module: multicycle_control
// PURPOSE
//  Multi-cycle sequencer for the MIPS datapath: a Moore FSM walks each instruction through
//  fetch/decode/execute/memory/writeback, driving mux selects, write strobes and ALUOp.
//  Sits between the instruction register (opcode) and the datapath.
//  Supports the same ISA subset as the single-cycle decoder: R-type, addi, lw, sw, beq, bne, bgtz.
// PARAMETERS
//  MEM_TIMEOUT  15  max wait cycles for mem_ready per access; 0 = wait forever
//  CNT_W        32  width of retired-instruction counter
// PORTS
//  clk          in   1      single clock, rising edge
//  rst_n        in   1      asynchronous reset, active low
//  opcode       in   6      IR[31:26], stable from end of FETCH until next FETCH
//  mem_ready    in   1      memory access completes this cycle
//  alu_zero     in   1      ALU result == 0
//  alu_pos      in   1      ALU result > 0 (signed)
//  pc_write     out  1      load PC (fetch increment or taken branch)
//  iord         out  1      memory address: 0=PC, 1=ALUOut
//  mem_read     out  1      memory read strobe
//  mem_write    out  1      memory write strobe
//  ir_write     out  1      load IR
//  reg_dst      out  1      write reg: 0=rt, 1=rd
//  mem_to_reg   out  1      write data: 0=ALUOut, 1=MDR
//  reg_write    out  1      register file write strobe
//  alu_src_a    out  1      0=PC, 1=reg A
//  alu_src_b    out  2      00=reg B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
//  alu_op       out  3      000 add, 001 sub, 010 funct decode, 011 gtz compare
//  pc_src       out  1      0=ALU result, 1=ALUOut (branch target)
//  state_o      out  4      current state encoding (debug)
//  instr_count  out  CNT_W  retired-instruction count
//  mem_timeout  out  1      one-cycle pulse: memory access abandoned
// BEHAVIOUR
//  - Reset: async to S_FETCH (enc 0); instr_count=0, wait counter=0. While rst_n=0, all outputs 0.
//  - Outputs are decoded from state (Moore); exceptions: pc_write/ir_write in FETCH gated by mem_ready,
//    pc_write in BRANCH gated by flags. Unlisted outputs are 0.
//  - S_FETCH(0): mem_read, iord=0, src_a=0, src_b=01, op=000; on mem_ready: ir_write, pc_write, pc_src=0 -> S_DECODE.
//  - S_DECODE(1): src_a=0, src_b=11, op=000 (branch target into ALUOut). Next by opcode:
//    000000 -> S_REXEC; 001000 -> S_IEXEC; 100011/101011 -> S_MEMADR; 000100/000101/000111 -> S_BRANCH.
//  - S_MEMADR(2): src_a=1, src_b=10, op=000 -> S_MEMRD (lw) | S_MEMWR (sw).
//  - S_MEMRD(3): mem_read, iord=1; wait mem_ready -> S_MEMWB(4): reg_write, mem_to_reg=1, reg_dst=0 -> S_FETCH.
//  - S_MEMWR(5): mem_write, iord=1; wait mem_ready -> S_FETCH.
//  - S_REXEC(6): src_a=1, src_b=00, op=010 -> S_RWB(7): reg_write, reg_dst=1 -> S_FETCH.
//  - S_IEXEC(8): src_a=1, src_b=10, op=000 -> S_IWB(9): reg_write, reg_dst=0 -> S_FETCH.
//  - S_BRANCH(10): src_a=1, src_b=00, pc_src=1; op=001 (beq/bne), 011 (bgtz);
//    pc_write = beq&alu_zero | bne&~alu_zero | bgtz&alu_pos -> S_FETCH.
//  - Latency (incl. fetch, zero-wait memory): R/addi 4, lw 5, sw 4, branch 3 cycles.
//  - Wait counter: cleared on entry to FETCH/MEMRD/MEMWR, increments each cycle mem_ready=0.
//    At count==MEM_TIMEOUT-1 with mem_ready=0 (MEM_TIMEOUT>0): pulse mem_timeout, drop strobes, -> S_FETCH;
//    no pc_write, ir_write or reg_write; instruction not counted. mem_ready on that same cycle wins.
//  - instr_count: +1 on the cycle leaving MEMWB, MEMWR (ready), RWB, IWB, BRANCH; wraps modulo 2^CNT_W.
//  - Illegal opcode handling: see CONFIGURATION.
//  - Reset mid-instruction: abandons access immediately; no strobe asserted while rst_n=0.
// CONFIGURATION
//  MC_CTRL_ILLEGAL_TRAP_EN defined: adds port illegal (out, 1); unknown opcode in DECODE -> S_TRAP(11):
//    illegal=1, all strobes 0, held until reset; not counted.
//  Undefined: no illegal port; unknown opcode DECODE -> S_FETCH as a NOP, counted as retired.
// TESTING
//  1. Reset low mid-S_MEMRD -> all outputs 0, state_o=0; release -> fetch with mem_read=1, iord=0.
//  2. opcode 000000, mem_ready=1 -> states 0,1,6,7,0; reg_dst=1 & reg_write=1 in state 7; count +1.
//  3. opcode 100011, mem_ready low 3 cycles in MEMRD -> MEMRD held 4 cycles, then MEMWB mem_to_reg=1.
//  4. opcode 000100: alu_zero=1 -> pc_write=1, pc_src=1 in BRANCH; 000101 with alu_zero=1 -> pc_write=0.
//  5. FETCH with mem_ready stuck 0, MEM_TIMEOUT=15 -> mem_timeout pulse on 15th cycle, state_o=0, no ir_write.
//  6. opcode 111111: with MC_CTRL_ILLEGAL_TRAP_EN -> state_o=11, illegal=1 held; without -> FETCH, count +1.

Source files
------------

// File: rtl/multicycle_control_if.sv
// Control/status bundle between the multi-cycle sequencer (master) and the MIPS datapath (slave).
// The illegal flag exists only when MC_CTRL_ILLEGAL_TRAP_EN is defined.
interface multicycle_control_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       opcode;
    logic             mem_ready;
    logic             alu_zero;
    logic             alu_pos;
    logic             pc_write;
    logic             iord;
    logic             mem_read;
    logic             mem_write;
    logic             ir_write;
    logic             reg_dst;
    logic             mem_to_reg;
    logic             reg_write;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [2:0]       alu_op;
    logic             pc_src;
    logic [3:0]       state_o;
    logic [CNT_W-1:0] instr_count;
    logic             mem_timeout;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    logic             illegal;
`endif

    modport master (
        input  opcode, mem_ready, alu_zero, alu_pos,
        output pc_write, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
               reg_write, alu_src_a, alu_src_b, alu_op, pc_src, state_o, instr_count,
               mem_timeout
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
             , illegal
`endif
    );

    modport slave (
        output opcode, mem_ready, alu_zero, alu_pos,
        input  pc_write, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
               reg_write, alu_src_a, alu_src_b, alu_op, pc_src, state_o, instr_count,
               mem_timeout
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
             , illegal
`endif
    );
endinterface

// File: rtl/multicycle_control.sv
// Moore multi-cycle sequencer for the MIPS subset (R-type, addi, lw, sw, beq, bne, bgtz).
// Define MC_CTRL_ILLEGAL_TRAP_EN to trap unknown opcodes instead of retiring them as NOPs.
module multicycle_control #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    multicycle_control_if.master   bus
);
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD = 4'd3,
        S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_REXEC  = 4'd6,  S_RWB   = 4'd7,
        S_IEXEC  = 4'd8,  S_IWB    = 4'd9,  S_BRANCH = 4'd10, S_TRAP  = 4'd11
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_BGTZ = 6'b000111;

    localparam int              WAIT_W   = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam bit              TO_EN    = (MEM_TIMEOUT > 0);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    state_t             state_q, state_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               wait_state, timeout, retire, br_take;

    assign wait_state = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
    assign timeout    = TO_EN && wait_state && !bus.mem_ready && (wait_q == WAIT_MAX);
    assign br_take    = ((bus.opcode == OP_BEQ)  &&  bus.alu_zero) ||
                        ((bus.opcode == OP_BNE)  && !bus.alu_zero) ||
                        ((bus.opcode == OP_BGTZ) &&  bus.alu_pos);

    // Leaving a wait state needs mem_ready or a timeout, so clearing on any non-stall gives "clear on entry".
    assign wait_d = (wait_state && !bus.mem_ready && !timeout) ? wait_q + 1'b1 : '0;
    assign cnt_d  = cnt_q + CNT_W'(retire);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            wait_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        case (state_q)
            S_FETCH:  if (bus.mem_ready) state_d = S_DECODE;
                      else if (timeout)  state_d = S_FETCH;
            S_DECODE: begin
                case (bus.opcode)
                    OP_R:                     state_d = S_REXEC;
                    OP_ADDI:                  state_d = S_IEXEC;
                    OP_LW, OP_SW:             state_d = S_MEMADR;
                    OP_BEQ, OP_BNE, OP_BGTZ:  state_d = S_BRANCH;
                    default: begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                        state_d = S_TRAP;
`else
                        state_d = S_FETCH;
                        retire  = 1'b1;
`endif
                    end
                endcase
            end
            S_MEMADR: state_d = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (bus.mem_ready) state_d = S_MEMWB;
                      else if (timeout)  state_d = S_FETCH;
            S_MEMWB:  begin state_d = S_FETCH; retire = 1'b1; end
            S_MEMWR:  if (bus.mem_ready) begin state_d = S_FETCH; retire = 1'b1; end
                      else if (timeout)  state_d = S_FETCH;
            S_REXEC:  state_d = S_RWB;
            S_RWB:    begin state_d = S_FETCH; retire = 1'b1; end
            S_IEXEC:  state_d = S_IWB;
            S_IWB:    begin state_d = S_FETCH; retire = 1'b1; end
            S_BRANCH: begin state_d = S_FETCH; retire = 1'b1; end
            S_TRAP:   state_d = S_TRAP;
            default:  state_d = S_FETCH;
        endcase
    end

    always_comb begin
        bus.pc_write    = 1'b0;
        bus.iord        = 1'b0;
        bus.mem_read    = 1'b0;
        bus.mem_write   = 1'b0;
        bus.ir_write    = 1'b0;
        bus.reg_dst     = 1'b0;
        bus.mem_to_reg  = 1'b0;
        bus.reg_write   = 1'b0;
        bus.alu_src_a   = 1'b0;
        bus.alu_src_b   = 2'b00;
        bus.alu_op      = 3'b000;
        bus.pc_src      = 1'b0;
        bus.mem_timeout = timeout;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        bus.illegal     = 1'b0;
`endif
        case (state_q)
            S_FETCH: begin
                bus.mem_read  = !timeout;
                bus.alu_src_b = 2'b01;
                bus.ir_write  = bus.mem_ready;
                bus.pc_write  = bus.mem_ready;
            end
            S_DECODE: bus.alu_src_b = 2'b11;
            S_MEMADR, S_IEXEC: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
            end
            S_MEMRD: begin bus.iord = 1'b1; bus.mem_read  = !timeout; end
            S_MEMWR: begin bus.iord = 1'b1; bus.mem_write = !timeout; end
            S_MEMWB: begin bus.reg_write = 1'b1; bus.mem_to_reg = 1'b1; end
            S_REXEC: begin bus.alu_src_a = 1'b1; bus.alu_op = 3'b010; end
            S_RWB:   begin bus.reg_write = 1'b1; bus.reg_dst = 1'b1; end
            S_IWB:   bus.reg_write = 1'b1;
            S_BRANCH: begin
                bus.alu_src_a = 1'b1;
                bus.pc_src    = 1'b1;
                bus.alu_op    = (bus.opcode == OP_BGTZ) ? 3'b011 : 3'b001;
                bus.pc_write  = br_take;
            end
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            S_TRAP:  bus.illegal = 1'b1;
`endif
            default: ;
        endcase
        // Reset forces every output low even though the reset state is FETCH.
        if (!rst_n) begin
            bus.pc_write    = 1'b0;
            bus.iord        = 1'b0;
            bus.mem_read    = 1'b0;
            bus.mem_write   = 1'b0;
            bus.ir_write    = 1'b0;
            bus.reg_dst     = 1'b0;
            bus.mem_to_reg  = 1'b0;
            bus.reg_write   = 1'b0;
            bus.alu_src_a   = 1'b0;
            bus.alu_src_b   = 2'b00;
            bus.alu_op      = 3'b000;
            bus.pc_src      = 1'b0;
            bus.mem_timeout = 1'b0;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            bus.illegal     = 1'b0;
`endif
        end
    end

    assign bus.state_o     = state_q;
    assign bus.instr_count = cnt_q;
endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: a vector table of full instructions plus
// hand-written wait-state, timeout, reset and illegal-opcode sequences.
module tb_multicycle_control;
    typedef struct {
        logic [5:0]  op;
        logic        rdy;
        logic        z;
        logic        p;
        logic [3:0]  st;
        logic [15:0] ctrl;
        logic [31:0] cnt;
    } vec_t;

    // Control word: pw io mr mw iw rd m2r rw sa sb[1:0] op[2:0] ps to
    localparam logic [15:0] C_FRDY  = 16'b1_0_1_0_1_0_0_0_0_01_000_0_0;
    localparam logic [15:0] C_FWAIT = 16'b0_0_1_0_0_0_0_0_0_01_000_0_0;
    localparam logic [15:0] C_FTO   = 16'b0_0_0_0_0_0_0_0_0_01_000_0_1;
    localparam logic [15:0] C_DEC   = 16'b0_0_0_0_0_0_0_0_0_11_000_0_0;
    localparam logic [15:0] C_ADR   = 16'b0_0_0_0_0_0_0_0_1_10_000_0_0;
    localparam logic [15:0] C_MRD   = 16'b0_1_1_0_0_0_0_0_0_00_000_0_0;
    localparam logic [15:0] C_MWB   = 16'b0_0_0_0_0_0_1_1_0_00_000_0_0;
    localparam logic [15:0] C_MWR   = 16'b0_1_0_1_0_0_0_0_0_00_000_0_0;
    localparam logic [15:0] C_MTO   = 16'b0_1_0_0_0_0_0_0_0_00_000_0_1;
    localparam logic [15:0] C_REX   = 16'b0_0_0_0_0_0_0_0_1_00_010_0_0;
    localparam logic [15:0] C_RWB   = 16'b0_0_0_0_0_1_0_1_0_00_000_0_0;
    localparam logic [15:0] C_IWB   = 16'b0_0_0_0_0_0_0_1_0_00_000_0_0;
    localparam logic [15:0] C_BEQT  = 16'b1_0_0_0_0_0_0_0_1_00_001_1_0;
    localparam logic [15:0] C_BEQN  = 16'b0_0_0_0_0_0_0_0_1_00_001_1_0;
    localparam logic [15:0] C_BGTT  = 16'b1_0_0_0_0_0_0_0_1_00_011_1_0;
    localparam logic [15:0] C_BGTN  = 16'b0_0_0_0_0_0_0_0_1_00_011_1_0;

    localparam logic [5:0] R = 6'b000000, ADDI = 6'b001000, LW = 6'b100011, SW = 6'b101011;
    localparam logic [5:0] BEQ = 6'b000100, BNE = 6'b000101, BGTZ = 6'b000111, ILL = 6'b111111;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    always #5 clk = ~clk;

    multicycle_control_if #(.CNT_W(32)) bus ();

    multicycle_control #(.MEM_TIMEOUT(15), .CNT_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    function automatic vec_t v(input logic [5:0] op, input logic rdy, input logic z, input logic p,
                               input logic [3:0] st, input logic [15:0] c, input int cnt);
        vec_t t;
        t.op = op; t.rdy = rdy; t.z = z; t.p = p; t.st = st; t.ctrl = c; t.cnt = 32'(cnt);
        return t;
    endfunction

    function automatic logic [15:0] act_ctrl();
        return {bus.pc_write, bus.iord, bus.mem_read, bus.mem_write, bus.ir_write, bus.reg_dst,
                bus.mem_to_reg, bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
                bus.pc_src, bus.mem_timeout};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic apply(input vec_t t, input string tag);
        @(negedge clk);
        bus.opcode = t.op; bus.mem_ready = t.rdy; bus.alu_zero = t.z; bus.alu_pos = t.p;
        #1;
        chk({tag, " state"}, 32'(bus.state_o), 32'(t.st));
        chk({tag, " ctrl"},  32'(act_ctrl()),  32'(t.ctrl));
        chk({tag, " count"}, bus.instr_count,  t.cnt);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst_n = 1'b0;
        bus.mem_ready = 1'b0;
        #1;
        chk({tag, " rst state"}, 32'(bus.state_o), 32'd0);
        chk({tag, " rst ctrl"},  32'(act_ctrl()),  32'd0);
        chk({tag, " rst count"}, bus.instr_count,  32'd0);
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        chk({tag, " rst illegal"}, 32'(bus.illegal), 32'd0);
`endif
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t tbl[$];
        bus.opcode = '0; bus.mem_ready = 1'b0; bus.alu_zero = 1'b0; bus.alu_pos = 1'b0;

        tbl.push_back(v(R,    1, 0, 0, 0,  C_FRDY, 0));
        tbl.push_back(v(R,    1, 0, 0, 1,  C_DEC,  0));
        tbl.push_back(v(R,    1, 0, 0, 6,  C_REX,  0));
        tbl.push_back(v(R,    1, 0, 0, 7,  C_RWB,  0));
        tbl.push_back(v(ADDI, 1, 0, 0, 0,  C_FRDY, 1));
        tbl.push_back(v(ADDI, 1, 0, 0, 1,  C_DEC,  1));
        tbl.push_back(v(ADDI, 1, 0, 0, 8,  C_ADR,  1));
        tbl.push_back(v(ADDI, 1, 0, 0, 9,  C_IWB,  1));
        tbl.push_back(v(SW,   1, 0, 0, 0,  C_FRDY, 2));
        tbl.push_back(v(SW,   1, 0, 0, 1,  C_DEC,  2));
        tbl.push_back(v(SW,   1, 0, 0, 2,  C_ADR,  2));
        tbl.push_back(v(SW,   1, 0, 0, 5,  C_MWR,  2));
        tbl.push_back(v(LW,   1, 0, 0, 0,  C_FRDY, 3));
        tbl.push_back(v(LW,   1, 0, 0, 1,  C_DEC,  3));
        tbl.push_back(v(LW,   1, 0, 0, 2,  C_ADR,  3));
        tbl.push_back(v(LW,   1, 0, 0, 3,  C_MRD,  3));
        tbl.push_back(v(LW,   1, 0, 0, 4,  C_MWB,  3));
        tbl.push_back(v(BEQ,  1, 1, 0, 0,  C_FRDY, 4));
        tbl.push_back(v(BEQ,  1, 1, 0, 1,  C_DEC,  4));
        tbl.push_back(v(BEQ,  1, 1, 0, 10, C_BEQT, 4));
        tbl.push_back(v(BNE,  1, 1, 0, 0,  C_FRDY, 5));
        tbl.push_back(v(BNE,  1, 1, 0, 1,  C_DEC,  5));
        tbl.push_back(v(BNE,  1, 1, 0, 10, C_BEQN, 5));
        tbl.push_back(v(BGTZ, 1, 0, 1, 0,  C_FRDY, 6));
        tbl.push_back(v(BGTZ, 1, 0, 1, 1,  C_DEC,  6));
        tbl.push_back(v(BGTZ, 1, 0, 1, 10, C_BGTT, 6));
        tbl.push_back(v(BNE,  1, 0, 0, 0,  C_FRDY, 7));
        tbl.push_back(v(BNE,  1, 0, 0, 1,  C_DEC,  7));
        tbl.push_back(v(BNE,  1, 0, 0, 10, C_BEQT, 7));
        tbl.push_back(v(BGTZ, 1, 1, 0, 0,  C_FRDY, 8));
        tbl.push_back(v(BGTZ, 1, 1, 0, 1,  C_DEC,  8));
        tbl.push_back(v(BGTZ, 1, 1, 0, 10, C_BGTN, 8));
        tbl.push_back(v(R,    0, 0, 0, 0,  C_FWAIT, 9));
        tbl.push_back(v(R,    1, 0, 0, 0,  C_FRDY, 9));

        do_reset("init");
        foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

        // lw with three wait cycles in MEMRD
        do_reset("lwwait");
        apply(v(LW, 1, 0, 0, 0, C_FRDY, 0), "lw3 fetch");
        apply(v(LW, 1, 0, 0, 1, C_DEC,  0), "lw3 dec");
        apply(v(LW, 1, 0, 0, 2, C_ADR,  0), "lw3 adr");
        for (int i = 0; i < 3; i++) apply(v(LW, 0, 0, 0, 3, C_MRD, 0), "lw3 wait");
        apply(v(LW, 1, 0, 0, 3, C_MRD,  0), "lw3 rdy");
        apply(v(LW, 0, 0, 0, 4, C_MWB,  0), "lw3 wb");
        apply(v(LW, 0, 0, 0, 0, C_FWAIT, 1), "lw3 next");

        // mem_ready on the last allowed cycle wins over the timeout
        apply(v(LW, 1, 0, 0, 0, C_FRDY, 1), "lw14 fetch");
        apply(v(LW, 1, 0, 0, 1, C_DEC,  1), "lw14 dec");
        apply(v(LW, 1, 0, 0, 2, C_ADR,  1), "lw14 adr");
        for (int i = 0; i < 14; i++) apply(v(LW, 0, 0, 0, 3, C_MRD, 1), "lw14 wait");
        apply(v(LW, 1, 0, 0, 3, C_MRD,  1), "lw14 rdy");
        apply(v(LW, 1, 0, 0, 4, C_MWB,  1), "lw14 wb");

        // MEMRD timeout: abandoned, not counted
        apply(v(LW, 1, 0, 0, 0, C_FRDY, 2), "lwto fetch");
        apply(v(LW, 1, 0, 0, 1, C_DEC,  2), "lwto dec");
        apply(v(LW, 1, 0, 0, 2, C_ADR,  2), "lwto adr");
        for (int i = 0; i < 14; i++) apply(v(LW, 0, 0, 0, 3, C_MRD, 2), "lwto wait");
        apply(v(LW, 0, 0, 0, 3, C_MTO,  2), "lwto pulse");
        apply(v(LW, 0, 0, 0, 0, C_FWAIT, 2), "lwto next");

        // reset in the middle of MEMRD
        apply(v(LW, 1, 0, 0, 0, C_FRDY, 2), "rmid fetch");
        apply(v(LW, 1, 0, 0, 1, C_DEC,  2), "rmid dec");
        apply(v(LW, 1, 0, 0, 2, C_ADR,  2), "rmid adr");
        apply(v(LW, 0, 0, 0, 3, C_MRD,  2), "rmid memrd");
        do_reset("rmid");
        apply(v(LW, 0, 0, 0, 0, C_FWAIT, 0), "rmid refetch");

        // FETCH timeout on the 15th stalled cycle, then counter restarts
        do_reset("fto");
        for (int i = 0; i < 14; i++) apply(v(R, 0, 0, 0, 0, C_FWAIT, 0), "fto wait");
        apply(v(R, 0, 0, 0, 0, C_FTO,   0), "fto pulse");
        apply(v(R, 0, 0, 0, 0, C_FWAIT, 0), "fto after");

        // MEMWR timeout: sw abandoned, not counted
        apply(v(SW, 1, 0, 0, 0, C_FRDY, 0), "swto fetch");
        apply(v(SW, 1, 0, 0, 1, C_DEC,  0), "swto dec");
        apply(v(SW, 1, 0, 0, 2, C_ADR,  0), "swto adr");
        for (int i = 0; i < 14; i++) apply(v(SW, 0, 0, 0, 5, C_MWR, 0), "swto wait");
        apply(v(SW, 0, 0, 0, 5, C_MTO,   0), "swto pulse");
        apply(v(SW, 0, 0, 0, 0, C_FWAIT, 0), "swto next");

        // illegal opcode
        apply(v(ILL, 1, 0, 0, 0, C_FRDY, 0), "ill fetch");
        apply(v(ILL, 1, 0, 0, 1, C_DEC,  0), "ill dec");
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        for (int i = 0; i < 3; i++) begin
            apply(v(ILL, 1, 0, 0, 11, 16'd0, 0), "ill trap");
            chk("ill flag", 32'(bus.illegal), 32'd1);
        end
`else
        apply(v(ILL, 0, 0, 0, 0, C_FWAIT, 1), "ill nop");
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
